// File: rtl/emmc_cclk_pkg.sv
// emmc_cclk_pkg: shared FSM encoding and reset-synchroniser depth for the eMMC card-clock generator.
package emmc_cclk_pkg;

    typedef enum logic [1:0] {
        CCLK_OFF   = 2'd0,
        CCLK_CFG   = 2'd1,
        CCLK_ON    = 2'd2,
        CCLK_DRAIN = 2'd3
    } cclk_state_e;

    localparam int unsigned RST_SYNC_DEPTH = 4;

    // Divider and delay line run only while the clock is up or draining.
    function automatic logic clk_running(input cclk_state_e s);
        return (s == CCLK_ON) || (s == CCLK_DRAIN);
    endfunction

endpackage

// File: rtl/emmc_cclk_tap.sv
// emmc_cclk_tap: per-output enable and gating register; lets a started high pulse finish, never starts a new one while draining.
module emmc_cclk_tap
    import emmc_cclk_pkg::*;
(
    input  logic        ext_clk,
    input  logic        rst_n,
    input  cclk_state_e state_i,
    input  logic        tap_i,
    output logic        en_o,
    output logic        out_o
);

    logic en_q, en_d;
    logic out_q, out_d;

    always_comb begin
        en_d = 1'b0;
        case (state_i)
            CCLK_ON:    en_d = 1'b1;
            // Stay enabled only while a pulse is in flight: output high and tap still high.
            CCLK_DRAIN: en_d = en_q && out_q && tap_i;
            default:    en_d = 1'b0;
        endcase
        out_d = tap_i & en_d;
    end

    always_ff @(posedge ext_clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q  <= 1'b0;
            out_q <= 1'b0;
        end else begin
            en_q  <= en_d;
            out_q <= out_d;
        end
    end

    assign en_o  = en_q;
    assign out_o = out_q;

endmodule

// File: rtl/emmc_cclk_gen.sv
// emmc_cclk_gen: programmable even-ratio card-clock divider with NUM_PH phase-delayed, glitch-free gated copies.
// Define EMMC_CCLK_UPDATE_EN to allow live re-capture of div_ctrl/phase_ctrl through cfg_update/cfg_ack.
module emmc_cclk_gen
    import emmc_cclk_pkg::*;
#(
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned PH_W   = 5,
    parameter int unsigned NUM_PH = 2
) (
    input  logic                   ext_clk,
    input  logic                   rst_n,
    input  logic                   clk_enable,
    input  logic [DIV_W-1:0]       div_ctrl,
    input  logic [NUM_PH*PH_W-1:0] phase_ctrl,
    input  logic                   cfg_update,
    output logic                   cfg_ack,
    output logic                   clk_ready,
    output logic                   cclk_out,
    output logic [NUM_PH-1:0]      cclk_ph_out
);

    localparam int unsigned DEPTH = 2 ** PH_W;

    logic [RST_SYNC_DEPTH-1:0] rst_sync_q;
    logic                      rst_int_n;
    logic [1:0]                en_sync_q;
    logic                      en_s;

    cclk_state_e               state_q, state_d;
    logic [DIV_W-1:0]          cnt_q, cnt_d;
    logic                      div_q, div_d;
    logic [DIV_W-1:0]          div_cfg_q, div_cfg_d;
    logic [NUM_PH*PH_W-1:0]    ph_cfg_q, ph_cfg_d;
    logic [DEPTH-1:0]          dly_q, dly_d;

    logic [NUM_PH:0]           tap_sel;
    logic [NUM_PH:0]           tap_en;
    logic [NUM_PH:0]           tap_out;
    logic                      upd_acc;
    logic                      upd_pend;

    // Reset asserts asynchronously, releases after RST_SYNC_DEPTH clean edges.
    always_ff @(posedge ext_clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[RST_SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[RST_SYNC_DEPTH-1];

    always_ff @(posedge ext_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            en_sync_q <= '0;
        end else begin
            en_sync_q <= {en_sync_q[0], clk_enable};
        end
    end

    assign en_s = en_sync_q[1];

`ifdef EMMC_CCLK_UPDATE_EN
    logic pend_q, pend_d;
    logic ack_q, ack_d;

    // A clk_enable fall in the same cycle wins: the update is dropped.
    assign upd_acc = (state_q == CCLK_ON) && en_s && cfg_update;

    always_comb begin
        pend_d = pend_q;
        ack_d  = 1'b0;
        if (state_q == CCLK_CFG) begin
            ack_d  = pend_q;
            pend_d = 1'b0;
        end else if (upd_acc) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge ext_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pend_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ack_q  <= ack_d;
        end
    end

    assign upd_pend = pend_q;
    assign cfg_ack  = ack_q;
`else
    // cfg_update stays on the port list so both builds share one footprint.
    assign upd_acc  = cfg_update & 1'b0;
    assign upd_pend = 1'b0;
    assign cfg_ack  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            CCLK_OFF:   if (en_s) state_d = CCLK_CFG;
            CCLK_CFG:   state_d = CCLK_ON;
            CCLK_ON:    if (!en_s || upd_acc) state_d = CCLK_DRAIN;
            CCLK_DRAIN: if (tap_en == '0) state_d = upd_pend ? CCLK_CFG : CCLK_OFF;
            default:    state_d = CCLK_OFF;
        endcase
    end

    always_comb begin
        div_cfg_d = div_cfg_q;
        ph_cfg_d  = ph_cfg_q;
        if (state_q == CCLK_CFG) begin
            div_cfg_d = div_ctrl;
            ph_cfg_d  = phase_ctrl;
        end
    end

    always_comb begin
        cnt_d = '0;
        div_d = 1'b0;
        dly_d = '0;
        if (clk_running(state_q)) begin
            dly_d = {dly_q[DEPTH-2:0], div_q};
            if (cnt_q == div_cfg_q) begin
                cnt_d = '0;
                div_d = ~div_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
                div_d = div_q;
            end
        end
    end

    always_ff @(posedge ext_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= CCLK_OFF;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            div_cfg_q <= '0;
            ph_cfg_q  <= '0;
            dly_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            div_cfg_q <= div_cfg_d;
            ph_cfg_q  <= ph_cfg_d;
            dly_q     <= dly_d;
        end
    end

    assign tap_sel[0] = dly_q[0];

    for (genvar p = 0; p < NUM_PH; p++) begin : g_phase
        assign tap_sel[p+1] = dly_q[ph_cfg_q[p*PH_W +: PH_W]];
    end

    for (genvar g = 0; g <= NUM_PH; g++) begin : g_tap
        emmc_cclk_tap u_tap (
            .ext_clk (ext_clk),
            .rst_n   (rst_int_n),
            .state_i (state_q),
            .tap_i   (tap_sel[g]),
            .en_o    (tap_en[g]),
            .out_o   (tap_out[g])
        );
    end

    assign clk_ready   = clk_running(state_q);
    assign cclk_out    = tap_out[0];
    assign cclk_ph_out = tap_out[NUM_PH:1];

endmodule

// File: tb/tb_emmc_cclk_gen.sv
// tb_emmc_cclk_gen: directed table-driven checks of emmc_cclk_gen timing, drain, update and reset behaviour.
module tb_emmc_cclk_gen;

`ifdef EMMC_CCLK_UPDATE_EN
    localparam int EXP_UPD_ACKS   = 1;
    localparam int EXP_UPD_PERIOD = 8;
`else
    localparam int EXP_UPD_ACKS   = 0;
    localparam int EXP_UPD_PERIOD = 4;
`endif

    typedef struct {
        int div;
        int ph0;
        int ph1;
        int exp_first;
        int exp_high;
        int exp_period;
    } vec_t;

    logic       ext_clk    = 1'b0;
    logic       rst_n      = 1'b1;
    logic       clk_enable = 1'b0;
    logic       cfg_update = 1'b0;
    logic [7:0] div_ctrl   = '0;
    logic [9:0] phase_ctrl = '0;
    logic       cfg_ack;
    logic       clk_ready;
    logic       cclk_out;
    logic [1:0] cclk_ph_out;

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;

    always #5 ext_clk = ~ext_clk;

    always @(negedge ext_clk) begin
        if (cfg_ack) ack_cnt <= ack_cnt + 1;
    end

    emmc_cclk_gen #(.DIV_W(8), .PH_W(5), .NUM_PH(2)) dut (
        .ext_clk     (ext_clk),
        .rst_n       (rst_n),
        .clk_enable  (clk_enable),
        .div_ctrl    (div_ctrl),
        .phase_ctrl  (phase_ctrl),
        .cfg_update  (cfg_update),
        .cfg_ack     (cfg_ack),
        .clk_ready   (clk_ready),
        .cclk_out    (cclk_out),
        .cclk_ph_out (cclk_ph_out)
    );

    task automatic tick();
        @(posedge ext_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_level(input logic lvl, input int bound, output int n);
        n = 0;
        while (clk_ready !== lvl && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        vec_t vecs[5];
        int n, r0, f0, r1, p0, p1;
        logic pc, pp0, pp1;
        int w[3];
        int pulses, drop_c, minw, lastp, lastr, ack_base, seen_ready;
        logic [2:0] outs;
        logic inp;

        vecs[0] = '{0,   0,  3,  3,   1,   2};
        vecs[1] = '{1,   2,  5,  4,   2,   4};
        vecs[2] = '{5,   1,  0,  8,   6,  12};
        vecs[3] = '{3,   7, 16,  6,   4,   8};
        vecs[4] = '{255, 0, 31, 258, 256, 512};

        // Asynchronous reset entry, then release.
        #2 rst_n = 1'b0;
        #1 chk("reset_outs", int'({cclk_out, cclk_ph_out, clk_ready, cfg_ack}), 0);
        tick();
        tick();
        chk("reset_hold", int'({cclk_out, cclk_ph_out, clk_ready, cfg_ack}), 0);
        rst_n = 1'b1;
        repeat (8) tick();

        foreach (vecs[i]) begin
            div_ctrl   = 8'(vecs[i].div);
            phase_ctrl = {5'(vecs[i].ph1), 5'(vecs[i].ph0)};
            clk_enable = 1'b1;
            wait_level(1'b1, 20, n);
            chk($sformatf("v%0d_ready_lat", i), n, 4);
            r0 = -1; f0 = -1; r1 = -1; p0 = -1; p1 = -1;
            pc = cclk_out; pp0 = cclk_ph_out[0]; pp1 = cclk_ph_out[1];
            for (int c = 1; c <= 1000 && (r1 < 0 || p0 < 0 || p1 < 0); c++) begin
                tick();
                if (cclk_out && !pc) begin
                    if (r0 < 0) r0 = c;
                    else if (r1 < 0) r1 = c;
                end
                if (!cclk_out && pc && r0 >= 0 && f0 < 0) f0 = c;
                if (cclk_ph_out[0] && !pp0 && p0 < 0) p0 = c;
                if (cclk_ph_out[1] && !pp1 && p1 < 0) p1 = c;
                pc = cclk_out; pp0 = cclk_ph_out[0]; pp1 = cclk_ph_out[1];
            end
            chk($sformatf("v%0d_first_rise", i), r0, vecs[i].exp_first);
            chk($sformatf("v%0d_high_width", i), f0 - r0, vecs[i].exp_high);
            chk($sformatf("v%0d_period", i), r1 - r0, vecs[i].exp_period);
            chk($sformatf("v%0d_ph0_lag", i), p0 - r0, vecs[i].ph0);
            chk($sformatf("v%0d_ph1_lag", i), p1 - r0, vecs[i].ph1);
            clk_enable = 1'b0;
            wait_level(1'b0, 2000, n);
            chk($sformatf("v%0d_ready_drop", i), int'(clk_ready), 0);
            chk($sformatf("v%0d_outs_idle", i), int'({cclk_out, cclk_ph_out}), 0);
            repeat (3) tick();
        end

        // Enable fall on the first cycle of a cclk_out pulse: pulses in flight complete, none start.
        div_ctrl   = 8'd3;
        phase_ctrl = {5'd5, 5'd1};
        clk_enable = 1'b1;
        wait_level(1'b1, 20, n);
        n = 0;
        while (!cclk_out && n < 50) begin
            tick();
            n++;
        end
        chk("drain_rise_seen", int'(cclk_out), 1);
        clk_enable = 1'b0;
        w[0] = int'(cclk_out); w[1] = int'(cclk_ph_out[0]); w[2] = int'(cclk_ph_out[1]);
        pulses = 0;
        drop_c = -1;
        for (int c = 0; c < 40; c++) begin
            tick();
            outs = {cclk_ph_out, cclk_out};
            for (int k = 0; k < 3; k++) begin
                if (outs[k]) begin
                    w[k]++;
                end else if (w[k] != 0) begin
                    chk($sformatf("drain_width_%0d", k), w[k], 4);
                    pulses++;
                    w[k] = 0;
                end
            end
            if (!clk_ready && drop_c < 0) drop_c = c;
        end
        chk("drain_pulses", pulses, 2);
        chk("drain_ready_drop", drop_c, 5);
        chk("drain_outs_idle", int'({cclk_out, cclk_ph_out, clk_ready}), 0);

        // Live update of div 1 -> 3.
        div_ctrl   = 8'd1;
        phase_ctrl = {5'd2, 5'd0};
        clk_enable = 1'b1;
        wait_level(1'b1, 20, n);
        chk("upd_ready_lat", n, 4);
        repeat (10) tick();
        div_ctrl   = 8'd3;
        ack_base   = ack_cnt;
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        minw = 99; lastp = 0; lastr = -1; inp = 1'b0; w[0] = 0;
        pc = cclk_out;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (cclk_out && !pc) begin
                if (lastr >= 0) lastp = c - lastr;
                lastr = c;
                inp   = 1'b1;
                w[0]  = 0;
            end
            if (cclk_out && inp) w[0]++;
            if (!cclk_out && pc && inp) begin
                if (w[0] < minw) minw = w[0];
                inp = 1'b0;
            end
            pc = cclk_out;
        end
        chk("upd_acks", ack_cnt - ack_base, EXP_UPD_ACKS);
        chk("upd_min_width", minw, 2);
        chk("upd_period", lastp, EXP_UPD_PERIOD);

        // Enable fall and cfg_update arriving on the same synchronised cycle.
        ack_base   = ack_cnt;
        clk_enable = 1'b0;
        tick();
        tick();
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        wait_level(1'b0, 200, n);
        chk("simul_ready_drop", int'(clk_ready), 0);
        seen_ready = 0;
        repeat (12) begin
            tick();
            if (clk_ready) seen_ready++;
        end
        chk("simul_stay_off", seen_ready, 0);
        chk("simul_acks", ack_cnt - ack_base, 0);

        // Asynchronous reset while running, release with enable still high.
        div_ctrl   = 8'd1;
        phase_ctrl = {5'd1, 5'd0};
        clk_enable = 1'b1;
        wait_level(1'b1, 20, n);
        n = 0;
        while (!cclk_out && n < 20) begin
            tick();
            n++;
        end
        chk("rst_running", int'(cclk_out), 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outs", int'({cclk_out, cclk_ph_out, clk_ready, cfg_ack}), 0);
        tick();
        tick();
        tick();
        rst_n = 1'b1;
        wait_level(1'b1, 30, n);
        chk("rst_release_to_on", n, 8);

        clk_enable = 1'b0;
        wait_level(1'b0, 200, n);
        chk("final_idle", int'({cclk_out, cclk_ph_out, clk_ready}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
